mod_counter_wrap_monitor: RTL

- Downstream consumer of the 4-bit MOD counter.
- Samples the counter's count, run-enable and MOD value, and checks that the count follows the legal sequence 0..TERM,0,...
- Emits a one-cycle tick on every legal wrap, keeps a saturating count of completed periods, and raises a sticky error on any illegal step.
- Gives the timer subsystem a period event and gives system-level benches a built-in self-check.

---
 rtl/mod_counter_wrap_monitor.sv | 93 +++++++++
 1 files changed

// File: rtl/mod_counter_wrap_monitor.sv
// Sequence monitor for the 4-bit MOD counter: checks the
// 0..TERM walk, emits wrap ticks and counts completed periods.
module mod_counter_wrap_monitor #(
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                    Clk_In,
  input  logic                    Resetb_In,
  input  logic                    Run_In,
  input  logic [3:0]              MOD_Value_In,
  input  logic [3:0]              Count_In,
  input  logic                    Clear_In,
  output logic                    Wrap_Tick_Out,
  output logic [PERIOD_WIDTH-1:0] Period_Count_Out,
  output logic                    Locked_Out,
  output logic                    Error_Out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [3:0] prev_count;
  logic [3:0] term_reg;
  logic       run_d;
  logic [3:0] next_exp;
  logic       step_ok;
  logic       wrap;
  logic       prev_load;
  logic       sat;

  assign next_exp = (prev_count == term_reg) ?
                    4'd0 : prev_count + 4'd1;

  // run_d tells whether the counter was allowed to move this edge
  assign step_ok = run_d ? (Count_In == next_exp)
                         : (Count_In == prev_count);

  assign wrap = (state == TRACK) && run_d && step_ok &&
                (prev_count == term_reg);

  assign prev_load = ((state == IDLE) && Run_In) ||
                     (state == SYNC) ||
                     ((state == TRACK) && step_ok);

  assign sat = &Period_Count_Out;

  assign Locked_Out = (state == TRACK);
  assign Error_Out  = (state == ERROR);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (Run_In) state_nx = SYNC;
      SYNC:    state_nx = TRACK;
      TRACK: begin
        if (!step_ok)     state_nx = ERROR;
        else if (!Run_In) state_nx = IDLE;
      end
      ERROR:   state_nx = ERROR;
      default: state_nx = IDLE;
    endcase
    if (Clear_In && (state_nx == ERROR))
      state_nx = IDLE;
  end

  always_ff @(posedge Clk_In or negedge Resetb_In) begin
    if (!Resetb_In) begin
      state            <= IDLE;
      prev_count       <= 4'd0;
      term_reg         <= 4'd0;
      run_d            <= 1'b0;
      Wrap_Tick_Out    <= 1'b0;
      Period_Count_Out <= '0;
    end else begin
      state         <= state_nx;
      run_d         <= Run_In;
      Wrap_Tick_Out <= wrap;
      if (prev_load)
        prev_count <= Count_In;
      if ((state == IDLE) && Run_In)
        term_reg <= MOD_Value_In - 4'd1;
      if (Clear_In)
        Period_Count_Out <= '0;
      else if (wrap && !sat)
        Period_Count_Out <= Period_Count_Out +
                            PERIOD_WIDTH'(1);
    end
  end

endmodule
